// File: rtl/valu_sched.sv
`default_nettype none
// ============================================================================
// Module   : valu_sched
// Purpose  : Round-robin scheduler that shares one 64-bit vector ALU
//            (VADD/VSUB/VMUL/VMAC, SEW 8/16/32) between NREQ requesters.
//            One operation is in flight at a time. A watchdog aborts a hung
//            ALU operation and pulses the ALU reset.
// Ports    : clk, rst_n         - clock, synchronous active-low reset
//            req_valid/ready    - per-requester handshake (ready one-hot)
//            req_op/sew/vs1/vs2 - packed per-requester request fields
//            rsp_valid/data/err - one-cycle one-hot response pulse
//            alu_*              - held operands, start pulse, done, result,
//                                 ALU reset
//            busy               - scheduler not idle
// Revision : 1.0 - initial release
// ============================================================================
module valu_sched #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [2*NREQ-1:0]    req_sew,
  input  logic [64*NREQ-1:0]   req_vs1,
  input  logic [64*NREQ-1:0]   req_vs2,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [63:0]          rsp_data,
  output logic                 rsp_err,
  output logic [1:0]           alu_op,
  output logic [1:0]           alu_sew,
  output logic [63:0]          alu_vs1,
  output logic [63:0]          alu_vs2,
  output logic                 alu_valid_in,
  input  logic                 alu_valid_out,
  input  logic [63:0]          alu_result,
  output logic                 alu_rst_n,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt;
  logic [TW-1:0]   tmo_cnt;

  logic            found;
  logic [IW-1:0]   grant;
  logic [IW:0]     cand;

  // Round-robin search starting at rr_ptr; the extra bit of cand lets the
  // wrap be done with a subtract, which also works for non-power-of-2 NREQ.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!found && req_valid[cand[IW-1:0]]) begin
        found = 1'b1;
        grant = cand[IW-1:0];
      end
    end
  end

  assign req_ready = (state == S_IDLE && found) ? (NREQ'(1) << grant) : '0;
  assign busy      = (state != S_IDLE);
  assign alu_rst_n = rst_n & (state != S_FLUSH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      gnt          <= '0;
      tmo_cnt      <= '0;
      alu_op       <= '0;
      alu_sew      <= '0;
      alu_vs1      <= '0;
      alu_vs2      <= '0;
      alu_valid_in <= 1'b0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      // Both pulses are single-cycle by construction.
      alu_valid_in <= 1'b0;
      rsp_valid    <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            alu_op  <= req_op[{grant, 1'b0} +: 2];
            alu_sew <= req_sew[{grant, 1'b0} +: 2];
            alu_vs1 <= req_vs1[{grant, 6'b0} +: 64];
            alu_vs2 <= req_vs2[{grant, 6'b0} +: 64];
            gnt     <= grant;
            if (req_sew[{grant, 1'b0} +: 2] == 2'b11) begin
              // Illegal element width: answer immediately, ALU untouched.
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= NREQ'(1) << grant;
              state     <= S_RESP;
            end else begin
              alu_valid_in <= 1'b1;
              state        <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_valid_out) begin
            rsp_data  <= alu_result;
            rsp_err   <= 1'b0;
            rsp_valid <= NREQ'(1) << gnt;
            state     <= S_RESP;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= S_FLUSH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          // alu_rst_n is low for this one cycle; report the abort next.
          rsp_valid <= NREQ'(1) << gnt;
          state     <= S_RESP;
        end
        S_RESP: begin
          rr_ptr <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
